// File: rtl/ws281x_rx.sv
// WS281x single-wire receiver: times each high pulse, assembles MSB-first 24-bit words,
// reports frame-end gaps and protocol errors. Define WS281X_RX_STATS_EN for word/error counters.
module ws281x_rx #(
    parameter int T1MinCycles   = 15,
    parameter int MinHighCycles = 3,
    parameter int MaxHighCycles = 50,
    parameter int ResetCycles   = 1250
) (
    input  logic        clk_i,
    input  logic        rst_i,
    input  logic        ws281x_din_i,
    output logic [23:0] data_o,
    output logic        data_valid_o,
    input  logic        data_ready_i,
    output logic        frame_end_o,
    output logic        err_o,
    output logic        overflow_o,
`ifdef WS281X_RX_STATS_EN
    output logic [15:0] word_count_o,
    output logic [7:0]  err_count_o,
`endif
    output logic        busy_o
);
    localparam int CW = $clog2(ResetCycles + 1);
    localparam logic [CW-1:0] CNT_MAX   = {CW{1'b1}};
    localparam logic [CW:0]   LEN_T1    = (CW+1)'(T1MinCycles);
    localparam logic [CW:0]   LEN_MIN   = (CW+1)'(MinHighCycles);
    localparam logic [CW:0]   LEN_MAX   = (CW+1)'(MaxHighCycles);
    localparam logic [CW:0]   LEN_RESET = (CW+1)'(ResetCycles);

    typedef enum logic [1:0] {
        RESYNC = 2'd0,
        ARMED  = 2'd1,
        HIGH   = 2'd2,
        LOW    = 2'd3
    } state_t;

    state_t        r_state;
    state_t        w_state_nx;
    logic          r_s1, r_s2, r_p;
    logic          w_rise, w_fall;
    logic [CW-1:0] r_cnt;
    logic [CW:0]   w_len;
    logic [4:0]    r_bitcnt;
    logic [22:0]   r_shift;
    logic [23:0]   w_shift_nx;
    logic [23:0]   r_data;
    logic          r_valid, r_frame_end, r_err, r_overflow, r_busy;
    logic          w_shift_en, w_bit, w_discard, w_err_ev, w_frame_ev;
    logic          w_word_done, w_load, w_overflow_ev;

    // Two-flop synchronizer plus previous-value flop for edge detection
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            r_s1 <= 1'b0;
            r_s2 <= 1'b0;
            r_p  <= 1'b0;
        end else begin
            r_s1 <= ws281x_din_i;
            r_s2 <= r_s1;
            r_p  <= r_s2;
        end
    end

    assign w_rise = r_s2 & ~r_p;
    assign w_fall = ~r_s2 & r_p;
    // Length of the current level, counting the edge cycle itself
    assign w_len  = {1'b0, r_cnt} + {{CW{1'b0}}, 1'b1};

    // Level-duration counter: restarts on every edge, saturates on a long idle line
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            r_cnt <= {CW{1'b0}};
        end else if (w_rise || w_fall) begin
            r_cnt <= {CW{1'b0}};
        end else if (r_cnt != CNT_MAX) begin
            r_cnt <= r_cnt + CW'(1);
        end
    end

    // State register
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            r_state <= RESYNC;
        end else begin
            r_state <= w_state_nx;
        end
    end

    // Next-state and per-cycle event decode
    always_comb begin
        w_state_nx = r_state;
        w_shift_en = 1'b0;
        w_bit      = 1'b0;
        w_discard  = 1'b0;
        w_err_ev   = 1'b0;
        w_frame_ev = 1'b0;
        case (r_state)
            RESYNC: begin
                if (!r_s2 && !w_fall && (w_len >= LEN_RESET)) begin
                    w_state_nx = ARMED;
                end else begin
                    w_state_nx = RESYNC;
                end
            end
            ARMED: begin
                if (w_rise) begin
                    w_state_nx = HIGH;
                    w_discard  = 1'b1;
                end else begin
                    w_state_nx = ARMED;
                end
            end
            HIGH: begin
                if (w_len > LEN_MAX) begin
                    w_err_ev   = 1'b1;
                    w_discard  = 1'b1;
                    w_state_nx = RESYNC;
                end else if (w_fall) begin
                    if (w_len < LEN_MIN) begin
                        w_err_ev   = 1'b1;
                        w_discard  = 1'b1;
                        w_state_nx = RESYNC;
                    end else begin
                        w_shift_en = 1'b1;
                        w_bit      = (w_len >= LEN_T1);
                        w_state_nx = LOW;
                    end
                end else begin
                    w_state_nx = HIGH;
                end
            end
            LOW: begin
                if (w_rise) begin
                    w_state_nx = HIGH;
                end else if (w_len >= LEN_RESET) begin
                    w_frame_ev = 1'b1;
                    w_discard  = 1'b1;
                    w_err_ev   = (r_bitcnt != 5'd0);
                    w_state_nx = ARMED;
                end else begin
                    w_state_nx = LOW;
                end
            end
            default: begin
                w_discard  = 1'b1;
                w_state_nx = RESYNC;
            end
        endcase
    end

    assign w_shift_nx    = {r_shift, w_bit};
    assign w_word_done   = w_shift_en && (r_bitcnt == 5'd23);
    assign w_load        = w_word_done && (!r_valid || data_ready_i);
    assign w_overflow_ev = w_word_done && !w_load;

    // Bit assembly, output word register, handshake and status pulses
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            r_bitcnt    <= 5'd0;
            r_shift     <= 23'd0;
            r_data      <= 24'd0;
            r_valid     <= 1'b0;
            r_overflow  <= 1'b0;
            r_err       <= 1'b0;
            r_frame_end <= 1'b0;
            r_busy      <= 1'b0;
        end else begin
            if (w_discard || w_word_done) begin
                r_bitcnt <= 5'd0;
                r_shift  <= 23'd0;
            end else if (w_shift_en) begin
                r_bitcnt <= r_bitcnt + 5'd1;
                r_shift  <= w_shift_nx[22:0];
            end
            if (w_load) begin
                r_data  <= w_shift_nx;
                r_valid <= 1'b1;
            end else if (r_valid && data_ready_i) begin
                r_valid <= 1'b0;
            end
            if (w_overflow_ev) begin
                r_overflow <= 1'b1;
            end
            r_err       <= w_err_ev | w_overflow_ev;
            r_frame_end <= w_frame_ev;
            r_busy      <= (w_state_nx == HIGH) || (w_state_nx == LOW);
        end
    end

`ifdef WS281X_RX_STATS_EN
    logic [15:0] r_word_count;
    logic [7:0]  r_err_count;

    // Saturating word and error counters
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            r_word_count <= 16'd0;
            r_err_count  <= 8'd0;
        end else begin
            if (w_load && (r_word_count != 16'hFFFF)) begin
                r_word_count <= r_word_count + 16'd1;
            end
            if ((w_err_ev || w_overflow_ev) && (r_err_count != 8'hFF)) begin
                r_err_count <= r_err_count + 8'd1;
            end
        end
    end

    assign word_count_o = r_word_count;
    assign err_count_o  = r_err_count;
`endif

    assign data_o       = r_data;
    assign data_valid_o = r_valid;
    assign frame_end_o  = r_frame_end;
    assign err_o        = r_err;
    assign overflow_o   = r_overflow;
    assign busy_o       = r_busy;
endmodule

// File: tb/tb_ws281x_rx.sv
// Self-checking bench for ws281x_rx: drives WS281x waveforms, scoreboards decoded words.
module tb_ws281x_rx;
    logic        clk = 1'b0;
    logic        rst_i;
    logic        din;
    logic        ready;
    logic [23:0] data_o;
    logic        data_valid_o, frame_end_o, err_o, overflow_o, busy_o;
`ifdef WS281X_RX_STATS_EN
    logic [15:0] word_count;
    logic [7:0]  err_count;
`endif

    int errors = 0;
    int checks = 0;
    int err_seen = 0;
    int fe_seen = 0;
    int both_seen = 0;
    int rx_seen = 0;
    logic [23:0] exp_q[$];

    always #5 clk = ~clk;

    ws281x_rx dut (
        .clk_i        (clk),
        .rst_i        (rst_i),
        .ws281x_din_i (din),
        .data_o       (data_o),
        .data_valid_o (data_valid_o),
        .data_ready_i (ready),
        .frame_end_o  (frame_end_o),
        .err_o        (err_o),
        .overflow_o   (overflow_o),
`ifdef WS281X_RX_STATS_EN
        .word_count_o (word_count),
        .err_count_o  (err_count),
`endif
        .busy_o       (busy_o)
    );

    // Monitor: counts pulses and pops the scoreboard on every accepted word
    always @(negedge clk) begin
        if (!rst_i) begin
            if (err_o) err_seen++;
            if (frame_end_o) fe_seen++;
            if (err_o && frame_end_o) both_seen++;
            if (data_valid_o && ready) begin
                logic [23:0] exp_w;
                rx_seen++;
                checks++;
                if (exp_q.size() == 0) begin
                    errors++;
                    $display("FAIL sb_unexpected: got %06h, no word expected", data_o);
                end else begin
                    exp_w = exp_q.pop_front();
                    if (data_o !== exp_w) begin
                        errors++;
                        $display("FAIL sb_word: got %06h want %06h", data_o, exp_w);
                    end
                end
            end
        end
    end

    task automatic hold(input logic lvl, input int n);
        din = lvl;
        repeat (n) begin
            @(posedge clk);
            #2;
        end
    endtask

    task automatic send_bit(input logic b);
        if (b) begin
            hold(1'b1, 20);
            hold(1'b0, 11);
        end else begin
            hold(1'b1, 8);
            hold(1'b0, 23);
        end
    endtask

    task automatic send_word(input logic [23:0] w);
        for (int i = 23; i >= 0; i--) send_bit(w[i]);
    endtask

    task automatic test_reset;
        rst_i = 1'b1;
        din   = 1'b0;
        ready = 1'b0;
        repeat (3) @(posedge clk);
        @(negedge clk);
        checks += 6;
        if (data_o !== 24'd0) begin errors++; $display("FAIL reset_data: got %06h want 000000", data_o); end
        if (data_valid_o !== 1'b0) begin errors++; $display("FAIL reset_valid: got %b want 0", data_valid_o); end
        if (frame_end_o !== 1'b0) begin errors++; $display("FAIL reset_frame_end: got %b want 0", frame_end_o); end
        if (err_o !== 1'b0) begin errors++; $display("FAIL reset_err: got %b want 0", err_o); end
        if (overflow_o !== 1'b0) begin errors++; $display("FAIL reset_overflow: got %b want 0", overflow_o); end
        if (busy_o !== 1'b0) begin errors++; $display("FAIL reset_busy: got %b want 0", busy_o); end
        @(posedge clk);
        #2;
        rst_i = 1'b0;
    endtask

    task automatic test_basic;
        logic [23:0] w;
        int e0, f0, r0;
        w = 24'hA5C30F;
        e0 = err_seen; f0 = fe_seen; r0 = rx_seen;
        ready = 1'b1;
        hold(1'b0, 1300);
        checks += 2;
        if (busy_o !== 1'b0) begin errors++; $display("FAIL basic_armed_busy: got %b want 0", busy_o); end
        if (fe_seen - f0 != 0) begin errors++; $display("FAIL basic_resync_frame_end: got %0d want 0", fe_seen - f0); end
        exp_q.push_back(w);
        for (int i = 23; i >= 1; i--) send_bit(w[i]);
        hold(1'b1, 20);
        din = 1'b0;
        repeat (3) @(negedge clk);
        checks++;
        if (data_valid_o !== 1'b0) begin errors++; $display("FAIL basic_latency_early: valid=%b want 0 at edge 2", data_valid_o); end
        @(negedge clk);
        checks++;
        if (data_valid_o !== 1'b1) begin errors++; $display("FAIL basic_latency: valid=%b want 1 at edge 3", data_valid_o); end
        @(posedge clk);
        #2;
        hold(1'b0, 1300);
        checks += 4;
        if (fe_seen - f0 != 1) begin errors++; $display("FAIL basic_frame_end: got %0d pulses want 1", fe_seen - f0); end
        if (err_seen - e0 != 0) begin errors++; $display("FAIL basic_err: got %0d pulses want 0", err_seen - e0); end
        if (rx_seen - r0 != 1) begin errors++; $display("FAIL basic_rx_count: got %0d want 1", rx_seen - r0); end
        if (busy_o !== 1'b0) begin errors++; $display("FAIL basic_busy_after_gap: got %b want 0", busy_o); end
    endtask

    task automatic test_back_to_back;
        int e0, f0, r0;
        e0 = err_seen; f0 = fe_seen;
        ready = 1'b0;
        exp_q.push_back(24'h000001);
        send_word(24'h000001);
        send_word(24'hFFFFFE);
        hold(1'b0, 5);
        checks += 4;
        if (data_o !== 24'h000001) begin errors++; $display("FAIL ovf_data_held: got %06h want 000001", data_o); end
        if (data_valid_o !== 1'b1) begin errors++; $display("FAIL ovf_valid: got %b want 1", data_valid_o); end
        if (overflow_o !== 1'b1) begin errors++; $display("FAIL ovf_flag: got %b want 1", overflow_o); end
        if (err_seen - e0 != 1) begin errors++; $display("FAIL ovf_err: got %0d pulses want 1", err_seen - e0); end
        ready = 1'b1;
        hold(1'b0, 1300);
        checks += 2;
        if (exp_q.size() != 0) begin errors++; $display("FAIL ovf_drain: got %0d pending want 0", exp_q.size()); end
        if (fe_seen - f0 != 1) begin errors++; $display("FAIL ovf_frame_end: got %0d want 1", fe_seen - f0); end
        e0 = err_seen; r0 = rx_seen;
        exp_q.push_back(24'h000001);
        exp_q.push_back(24'hFFFFFE);
        send_word(24'h000001);
        send_word(24'hFFFFFE);
        hold(1'b0, 1300);
        checks += 4;
        if (rx_seen - r0 != 2) begin errors++; $display("FAIL b2b_rx_count: got %0d want 2", rx_seen - r0); end
        if (exp_q.size() != 0) begin errors++; $display("FAIL b2b_pending: got %0d want 0", exp_q.size()); end
        if (err_seen - e0 != 0) begin errors++; $display("FAIL b2b_err: got %0d want 0", err_seen - e0); end
        if (overflow_o !== 1'b1) begin errors++; $display("FAIL b2b_overflow_sticky: got %b want 1", overflow_o); end
    endtask

    task automatic test_glitch;
        int e0, f0, r0;
        e0 = err_seen; f0 = fe_seen; r0 = rx_seen;
        send_bit(1'b1); send_bit(1'b0); send_bit(1'b1); send_bit(1'b1); send_bit(1'b0);
        hold(1'b1, 2);
        hold(1'b0, 20);
        checks += 3;
        if (err_seen - e0 != 1) begin errors++; $display("FAIL glitch_err: got %0d want 1", err_seen - e0); end
        if (busy_o !== 1'b0) begin errors++; $display("FAIL glitch_resync_busy: got %b want 0", busy_o); end
        if (data_valid_o !== 1'b0) begin errors++; $display("FAIL glitch_valid: got %b want 0", data_valid_o); end
        hold(1'b0, 1300);
        exp_q.push_back(24'h123456);
        send_word(24'h123456);
        hold(1'b0, 1300);
        checks += 4;
        if (rx_seen - r0 != 1) begin errors++; $display("FAIL glitch_rx_count: got %0d want 1", rx_seen - r0); end
        if (exp_q.size() != 0) begin errors++; $display("FAIL glitch_pending: got %0d want 0", exp_q.size()); end
        if (err_seen - e0 != 1) begin errors++; $display("FAIL glitch_err_total: got %0d want 1", err_seen - e0); end
        if (fe_seen - f0 != 1) begin errors++; $display("FAIL glitch_frame_end: got %0d want 1", fe_seen - f0); end
    endtask

    task automatic test_long_high;
        int e0, f0, b0, r0;
        e0 = err_seen; f0 = fe_seen; b0 = both_seen; r0 = rx_seen;
        hold(1'b1, 60);
        hold(1'b0, 10);
        checks += 2;
        if (err_seen - e0 != 1) begin errors++; $display("FAIL long_high_err: got %0d want 1", err_seen - e0); end
        if (busy_o !== 1'b0) begin errors++; $display("FAIL long_high_busy: got %b want 0", busy_o); end
        hold(1'b0, 1300);
        checks++;
        if (fe_seen - f0 != 0) begin errors++; $display("FAIL long_high_resync_fe: got %0d want 0", fe_seen - f0); end
        for (int i = 0; i < 12; i++) send_bit(i[0]);
        hold(1'b0, 1300);
        checks += 4;
        if (fe_seen - f0 != 1) begin errors++; $display("FAIL partial_frame_end: got %0d want 1", fe_seen - f0); end
        if (err_seen - e0 != 2) begin errors++; $display("FAIL partial_err: got %0d want 2", err_seen - e0); end
        if (both_seen - b0 != 1) begin errors++; $display("FAIL partial_coincident: got %0d want 1", both_seen - b0); end
        if (rx_seen - r0 != 0) begin errors++; $display("FAIL partial_no_word: got %0d want 0", rx_seen - r0); end
    endtask

    task automatic test_boundary;
        int widths[4] = '{3, 14, 15, 50};
        int e0, r0;
        e0 = err_seen; r0 = rx_seen;
        exp_q.push_back(24'h333333);
        for (int i = 0; i < 24; i++) begin
            hold(1'b1, widths[i % 4]);
            hold(1'b0, 10);
        end
        hold(1'b0, 1300);
        checks += 2;
        if (rx_seen - r0 != 1) begin errors++; $display("FAIL boundary_rx_count: got %0d want 1", rx_seen - r0); end
        if (err_seen - e0 != 0) begin errors++; $display("FAIL boundary_err: got %0d want 0", err_seen - e0); end
    endtask

    task automatic test_loopback;
        logic [23:0] w;
        int e0, f0, r0;
        w = 24'h00FF80;
        e0 = err_seen; f0 = fe_seen; r0 = rx_seen;
        for (int n = 0; n < 20; n++) begin
            exp_q.push_back(w);
            for (int i = 23; i >= 0; i--) begin
                if (w[i]) hold(1'b1, int'($urandom_range(15, 50)));
                else      hold(1'b1, int'($urandom_range(3, 14)));
                hold(1'b0, int'($urandom_range(4, 20)));
            end
        end
        hold(1'b0, 1300);
        checks += 4;
        if (rx_seen - r0 != 20) begin errors++; $display("FAIL loop_rx_count: got %0d want 20", rx_seen - r0); end
        if (exp_q.size() != 0) begin errors++; $display("FAIL loop_pending: got %0d want 0", exp_q.size()); end
        if (err_seen - e0 != 0) begin errors++; $display("FAIL loop_err: got %0d want 0", err_seen - e0); end
        if (fe_seen - f0 != 1) begin errors++; $display("FAIL loop_frame_end: got %0d want 1", fe_seen - f0); end
    endtask

    task automatic test_mid_reset;
        int e0, f0, r0;
        for (int i = 0; i < 10; i++) send_bit(i[0]);
        rst_i = 1'b1;
        hold(1'b0, 3);
        checks += 3;
        if (data_valid_o !== 1'b0) begin errors++; $display("FAIL midrst_valid: got %b want 0", data_valid_o); end
        if (overflow_o !== 1'b0) begin errors++; $display("FAIL midrst_overflow: got %b want 0", overflow_o); end
        if (busy_o !== 1'b0) begin errors++; $display("FAIL midrst_busy: got %b want 0", busy_o); end
        rst_i = 1'b0;
        e0 = err_seen; f0 = fe_seen; r0 = rx_seen;
        hold(1'b0, 1300);
        exp_q.push_back(24'h7E7E7E);
        send_word(24'h7E7E7E);
        hold(1'b0, 1300);
        checks += 4;
        if (rx_seen - r0 != 1) begin errors++; $display("FAIL midrst_rx_count: got %0d want 1", rx_seen - r0); end
        if (exp_q.size() != 0) begin errors++; $display("FAIL midrst_pending: got %0d want 0", exp_q.size()); end
        if (err_seen - e0 != 0) begin errors++; $display("FAIL midrst_err: got %0d want 0", err_seen - e0); end
        if (fe_seen - f0 != 1) begin errors++; $display("FAIL midrst_frame_end: got %0d want 1", fe_seen - f0); end
`ifdef WS281X_RX_STATS_EN
        checks += 2;
        if (word_count !== 16'd1) begin errors++; $display("FAIL stats_words: got %0d want 1", word_count); end
        if (err_count !== 8'd0) begin errors++; $display("FAIL stats_errs: got %0d want 0", err_count); end
`endif
    endtask

    initial begin
        test_reset();
        test_basic();
        test_back_to_back();
        test_glitch();
        test_long_high();
        test_boundary();
        test_loopback();
        test_mid_reset();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
